lsu: RTL and testbench
======================

// Module: lsu
// PURPOSE
//  Load/store unit between ALU result (address) and the rd write-back mux; supplies the
//  memory value for REG_SEL memory path. Decodes address into data RAM or fifo_if MMIO
//  window, performs byte/half/word access with sign/zero extension, stalls control via busy_o.
// PARAMETERS
//  DMEM_BASE    32'h0001_0000  byte base of data RAM window
//  DMEM_WORDS   1024           data RAM depth in 32-bit words (power of 2)
//  MMIO_BASE    32'h0002_0000  base of 4-byte fifo_if register window
// PORTS
//  clk_i          in   1   clock
//  rstn_i         in   1   asynchronous reset, active-low
//  req_valid_i    in   1   memory instruction present this cycle
//  req_we_i       in   1   1=store, 0=load
//  req_size_i     in   2   `LSU_SIZE_B / `LSU_SIZE_H / `LSU_SIZE_W
//  req_unsigned_i in   1   load zero-extends (LBU/LHU)
//  addr_i         in   32  byte address (ALU result)
//  wdata_i        in   32  store data (rs2), value right-aligned
//  busy_o         out  1   stall: control must hold pc and request while high
//  rdata_o        out  32  extended load result, valid with rdata_valid_o
//  rdata_valid_o  out  1   one-cycle pulse: write rdata_o to rd
//  misaligned_o   out  1   one-cycle pulse: misaligned access dropped
//  decode_err_o   out  1   one-cycle pulse: address outside both windows
//  fifo_sel_o,fifo_rd_o,fifo_wr_o out 1 each; fifo_addr_o out 2; fifo_wrdata_o out 8
//  fifo_rddata_i  in   8   fifo_if read data, valid cycle after fifo_rd_o
// BEHAVIOUR
//  - Reset: state IDLE; busy_o, rdata_valid_o, misaligned_o, decode_err_o, fifo_* = 0;
//    rdata_o = 0. RAM contents not reset. Reset mid-load abandons it, no pulse after release.
//  - Accept only in IDLE with req_valid_i. busy_o = (state!=IDLE) | (req_valid_i & ~req_we_i
//    & state==IDLE); stores never stall. Requests while busy are not sampled.
//  - Misaligned: H with addr[0]=1, W with addr[1:0]!=0. Store: dropped, misaligned_o pulse
//    at N+1. Load: no access, rdata_o=0 with rdata_valid_o and misaligned_o at N+1.
//  - Unmapped address: same as misaligned but decode_err_o instead. Misaligned wins if both.
//  - RAM store (accept cycle N): written at edge ending N; byte lanes: B -> lane addr[1:0],
//    H -> lanes {2*addr[1]+1,2*addr[1]}, W -> all; data replicated into selected lanes.
//  - RAM load: N accept -> state MEM_RD; N+1 rdata_valid_o=1, rdata_o = selected lane(s)
//    shifted down, sign-extended unless req_unsigned_i (registered at accept). Back to IDLE.
//  - MMIO: byte-wide only; H/W accesses use low byte, no misalign check beyond size rules.
//    Store: fifo_sel_o=fifo_wr_o=1 at N+1 (registered), fifo_addr_o=addr[1:0],
//    fifo_wrdata_o=wdata_i[7:0]; no stall. Load: N -> IO_RD (fifo_sel_o=fifo_rd_o=1 at N+1)
//    -> IO_WAIT (N+2: sample fifo_rddata_i, rdata_valid_o=1, extend per size/unsigned).
//  - Latency: RAM load 1 cycle, MMIO load 2 cycles; throughput one load per 2/3 cycles.
//  - Store accepted in cycle after a load completes is legal (IDLE restored at N+1 edge).
//  - All output pulses exactly one cycle; fifo_* zero whenever not pulsing.
//  - Address window match: (addr_i - BASE) < size, unsigned 32-bit compare; RAM index
//    = offset[$clog2(DMEM_WORDS)+1:2].
// STRUCTURE
//  - const.v: `LSU_SIZE_B/H/W, `DMEM_BASE, `MMIO_BASE, `REG_SEL_MEM.
//  - Sub-module mem_data: sync-read 32-bit RAM with 4 byte-enables, optional hex init file.
//  - lsu: decode, align/extend, 4-state FSM (IDLE, MEM_RD, IO_RD, IO_WAIT).
// TESTING
//  - SW 0x12345678 @0x10000, LW @0x10000 -> busy_o 1 cycle, rdata_o=0x12345678 at N+1.
//  - SB 0x80 @0x10003, LB @0x10003 -> 0xFFFFFF80; LBU -> 0x00000080; other lanes intact.
//  - SH 0xBEEF @0x10002, LH -> 0xFFFFBEEF; LHU @0x10002 -> 0x0000BEEF; LW -> 0xBEEF5678.
//  - LW @0x10001 -> no RAM read, rdata 0, misaligned_o+rdata_valid_o at N+1; SW @0x10002
//    -> RAM unchanged, misaligned_o pulse.
//  - SB 0x41 @0x20001 -> fifo_wr_o,fifo_sel_o at N+1, addr=1, wrdata=0x41; LBU @0x20000
//    with fifo_rddata_i=0x7F -> fifo_rd_o at N+1, rdata_o=0x7F at N+2.
//  - LW @0x30000 -> decode_err_o, rdata 0; rstn_i low during MEM_RD -> no rdata_valid_o,
//    IDLE after release, next load works.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared constants, FSM state type and load alignment helpers for the load/store unit.
package lsu_pkg;

  localparam logic [1:0]  LSU_SIZE_B     = 2'b00;
  localparam logic [1:0]  LSU_SIZE_H     = 2'b01;
  localparam logic [1:0]  LSU_SIZE_W     = 2'b10;

  localparam logic [31:0] DMEM_BASE_DEF  = 32'h0001_0000;
  localparam int unsigned DMEM_WORDS_DEF = 1024;
  localparam logic [31:0] MMIO_BASE_DEF  = 32'h0002_0000;
  localparam logic [1:0]  REG_SEL_MEM    = 2'd2;

  typedef enum logic [1:0] {StIdle, StMemRd, StIoRd, StIoWait} lsu_state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      LSU_SIZE_B: return 1'b0;
      LSU_SIZE_H: return off[0];
      default:    return off != 2'b00;
    endcase
  endfunction

  // Pick the addressed byte/half out of a word and sign- or zero-extend it.
  function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      LSU_SIZE_B: return uns ? {24'h0, b} : {{24{b[7]}}, b};
      LSU_SIZE_H: return uns ? {16'h0, h} : {{16{h[15]}}, h};
      default:    return word;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_data.sv
// Synchronous-read 32-bit data RAM with per-byte write enables; contents are not reset.
module lsu_mem_data #(
  parameter int unsigned Words = 1024,
  localparam int unsigned Aw   = $clog2(Words)
) (
  input  logic          clk_i,
  input  logic          req_i,
  input  logic          we_i,
  input  logic [Aw-1:0] addr_i,
  input  logic [3:0]    be_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [Words];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (req_i) begin
      if (we_i) begin
        for (int i = 0; i < 4; i++) begin
          if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lsu.sv
// Load/store unit: decodes the ALU address into data RAM or the fifo_if MMIO window,
// aligns and extends loads, and stalls the pipeline while a load is outstanding.
module lsu
  import lsu_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE  = DMEM_BASE_DEF,
  parameter int unsigned DMEM_WORDS = DMEM_WORDS_DEF,
  parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEF
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        misaligned_o,
  output logic        decode_err_o,
  output logic        fifo_sel_o,
  output logic        fifo_rd_o,
  output logic        fifo_wr_o,
  output logic [1:0]  fifo_addr_o,
  output logic [7:0]  fifo_wrdata_o,
  input  logic [7:0]  fifo_rddata_i
);

  localparam int unsigned Aw        = $clog2(DMEM_WORDS);
  localparam logic [31:0] DmemBytes = 32'(DMEM_WORDS) << 2;

  lsu_state_e  state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  off_q, off_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        misal_q, misal_d;
  logic        dec_err_q, dec_err_d;
  logic        err_ld_q, err_ld_d;
  logic        fifo_wr_q, fifo_wr_d;

  logic        idle, accept, misal, ok;
  logic [31:0] dmem_off, mmio_off;
  logic        in_dmem, in_mmio;
  logic        ram_req, ram_ld, mmio_ld;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata, ram_rdata;

  // Unsigned offset compare handles addresses below the base by wrap-around.
  assign dmem_off = addr_i - DMEM_BASE;
  assign mmio_off = addr_i - MMIO_BASE;
  assign in_dmem  = dmem_off < DmemBytes;
  assign in_mmio  = mmio_off < 32'd4;

  assign idle    = state_q == StIdle;
  assign accept  = idle & req_valid_i;
  assign misal   = is_misaligned(req_size_i, addr_i[1:0]);
  assign ok      = accept & ~misal;
  assign ram_req = ok & in_dmem;
  assign ram_ld  = ram_req & ~req_we_i;
  assign mmio_ld = ok & ~in_dmem & in_mmio & ~req_we_i;

  always_comb begin
    ram_be    = 4'b1111;
    ram_wdata = wdata_i;
    case (req_size_i)
      LSU_SIZE_B: begin
        ram_be    = 4'b0001 << addr_i[1:0];
        ram_wdata = {4{wdata_i[7:0]}};
      end
      LSU_SIZE_H: begin
        ram_be    = addr_i[1] ? 4'b1100 : 4'b0011;
        ram_wdata = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  lsu_mem_data #(
    .Words(DMEM_WORDS)
  ) u_mem_data (
    .clk_i  (clk_i),
    .req_i  (ram_req),
    .we_i   (req_we_i),
    .addr_i (dmem_off[Aw+1:2]),
    .be_i   (ram_be),
    .wdata_i(ram_wdata),
    .rdata_o(ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (ram_ld)       state_d = StMemRd;
        else if (mmio_ld) state_d = StIoRd;
      end
      StMemRd:  state_d = StIdle;
      StIoRd:   state_d = StIoWait;
      StIoWait: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    size_d  = size_q;
    uns_d   = uns_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    if (accept) begin
      size_d  = req_size_i;
      uns_d   = req_unsigned_i;
      off_d   = addr_i[1:0];
      wdata_d = wdata_i[7:0];
    end
    misal_d   = accept & misal;
    dec_err_d = accept & ~misal & ~in_dmem & ~in_mmio;
    err_ld_d  = (misal_d | dec_err_d) & ~req_we_i;
    fifo_wr_d = ok & ~in_dmem & in_mmio & req_we_i;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= StIdle;
      size_q    <= LSU_SIZE_B;
      uns_q     <= 1'b0;
      off_q     <= 2'b00;
      wdata_q   <= 8'h00;
      misal_q   <= 1'b0;
      dec_err_q <= 1'b0;
      err_ld_q  <= 1'b0;
      fifo_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      off_q     <= off_d;
      wdata_q   <= wdata_d;
      misal_q   <= misal_d;
      dec_err_q <= dec_err_d;
      err_ld_q  <= err_ld_d;
      fifo_wr_q <= fifo_wr_d;
    end
  end

  always_comb begin
    busy_o        = ~idle | (req_valid_i & ~req_we_i);
    rdata_valid_o = (state_q == StMemRd) | (state_q == StIoWait) | err_ld_q;
    misaligned_o  = misal_q;
    decode_err_o  = dec_err_q;
    fifo_rd_o     = state_q == StIoRd;
    fifo_wr_o     = fifo_wr_q;
    fifo_sel_o    = fifo_rd_o | fifo_wr_o;
    fifo_addr_o   = fifo_sel_o ? off_q : 2'b00;
    fifo_wrdata_o = fifo_wr_q ? wdata_q : 8'h00;
    rdata_o       = 32'h0;
    case (state_q)
      StMemRd:  rdata_o = extend_load(ram_rdata, size_q, off_q, uns_q);
      // MMIO data is a single byte placed in the low lane before extension.
      StIoWait: rdata_o = extend_load({24'h0, fifo_rddata_i}, size_q, 2'b00, uns_q);
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus randomized traffic against a
// byte-array memory model.
module tb_lsu;

  localparam logic [1:0] SzB = 2'd0, SzH = 2'd1, SzW = 2'd2;

  logic        clk_i = 1'b0, rstn_i = 1'b0;
  logic        req_valid_i = 1'b0, req_we_i = 1'b0, req_unsigned_i = 1'b0;
  logic [1:0]  req_size_i = 2'd0;
  logic [31:0] addr_i = 32'h0, wdata_i = 32'h0;
  logic [7:0]  fifo_rddata_i = 8'h0;
  logic        busy_o, rdata_valid_o, misaligned_o, decode_err_o;
  logic        fifo_sel_o, fifo_rd_o, fifo_wr_o;
  logic [31:0] rdata_o;
  logic [1:0]  fifo_addr_o;
  logic [7:0]  fifo_wrdata_o;

  int errors = 0, checks = 0;
  logic [7:0] mem_m [4096];

  lsu dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .req_valid_i(req_valid_i), .req_we_i(req_we_i),
    .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .busy_o(busy_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
    .misaligned_o(misaligned_o), .decode_err_o(decode_err_o), .fifo_sel_o(fifo_sel_o),
    .fifo_rd_o(fifo_rd_o), .fifo_wr_o(fifo_wr_o), .fifo_addr_o(fifo_addr_o),
    .fifo_wrdata_o(fifo_wrdata_o), .fifo_rddata_i(fifo_rddata_i)
  );

  always #5 clk_i = ~clk_i;

  // ---------------- reference model ----------------
  function automatic logic in_ram(input logic [31:0] a);
    return a >= 32'h0001_0000 && a < 32'h0001_1000;
  endfunction
  function automatic logic in_mmio(input logic [31:0] a);
    return a >= 32'h0002_0000 && a < 32'h0002_0004;
  endfunction
  function automatic logic is_misal(input logic [1:0] sz, input logic [31:0] a);
    return (sz == SzH && (a % 2) != 0) || (sz == SzW && (a % 4) != 0);
  endfunction
  function automatic void apply_store(input logic [31:0] a, input logic [1:0] sz,
                                      input logic [31:0] wd);
    int off;
    if (is_misal(sz, a) || !in_ram(a)) return;
    off = int'(a - 32'h0001_0000);
    for (int i = 0; i < (1 << sz); i++) mem_m[off + i] = wd[8*i +: 8];
  endfunction
  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [1:0] sz,
                                           input logic uns);
    int n, off;
    logic [63:0] v;
    if (is_misal(sz, a) || !in_ram(a)) return 32'h0;
    n = 1 << sz;
    off = int'(a - 32'h0001_0000);
    v = 64'h0;
    for (int i = 0; i < n; i++) v = v | ({56'h0, mem_m[off + i]} << (8 * i));
    if (!uns && v[8*n-1]) v = v | (64'hFFFF_FFFF_FFFF_FFFF << (8 * n));
    return v[31:0];
  endfunction
  function automatic logic [31:0] exp_io(input logic [7:0] b, input logic uns);
    return uns ? {24'h0, b} : {{24{b[7]}}, b};
  endfunction
  function automatic logic [31:0] pool_addr();
    int w;
    w = $urandom_range(0, 16);
    if (w == 16) w = 1023;
    return 32'h0001_0000 + 32'(w * 4) + 32'($urandom_range(0, 3));
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask
  task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid_i = 1'b1; req_we_i = we; req_size_i = sz; req_unsigned_i = uns;
    addr_i = a; wdata_i = wd;
  endtask
  task automatic idle_req();
    req_valid_i = 1'b0; req_we_i = 1'b0;
  endtask

  // Load through RAM or error path; captures busy at N, flags/data at N+1, flags at N+2.
  task automatic do_load(input logic [1:0] sz, input logic uns, input logic [31:0] a,
                         output logic bsy, output logic [2:0] flg, output logic [31:0] rd,
                         output logic [3:0] aft);
    drive(1'b0, sz, uns, a, 32'h0);
    #1 bsy = busy_o;
    step(); idle_req();
    flg = {rdata_valid_o, misaligned_o, decode_err_o};
    rd = rdata_o;
    step();
    aft = {rdata_valid_o, misaligned_o, decode_err_o, busy_o};
  endtask

  // Store; flg at N+1 is {misaligned, decode_err, fifo_sel, fifo_rd, fifo_wr}.
  task automatic do_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                          output logic bsy, output logic [4:0] flg, output logic [1:0] fa,
                          output logic [7:0] fd, output logic [4:0] aft);
    drive(1'b1, sz, 1'b0, a, wd);
    apply_store(a, sz, wd);
    #1 bsy = busy_o;
    step(); idle_req();
    flg = {misaligned_o, decode_err_o, fifo_sel_o, fifo_rd_o, fifo_wr_o};
    fa = fifo_addr_o; fd = fifo_wrdata_o;
    step();
    aft = {misaligned_o, decode_err_o, fifo_sel_o, fifo_rd_o, fifo_wr_o};
  endtask

  // MMIO load; n1 = {fifo_sel, fifo_rd, fifo_wr, rdata_valid, busy} at N+1.
  task automatic do_io_load(input logic uns, input logic [31:0] a, input logic [7:0] b,
                            output logic bsy, output logic [4:0] n1, output logic [1:0] fa,
                            output logic v2, output logic [31:0] rd2, output logic [2:0] f2);
    fifo_rddata_i = ~b;
    drive(1'b0, SzB, uns, a, 32'h0);
    #1 bsy = busy_o;
    step(); idle_req();
    n1 = {fifo_sel_o, fifo_rd_o, fifo_wr_o, rdata_valid_o, busy_o};
    fa = fifo_addr_o;
    step();
    fifo_rddata_i = b;
    #1;
    v2 = rdata_valid_o; rd2 = rdata_o;
    f2 = {fifo_sel_o, fifo_rd_o, fifo_wr_o};
    step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #3;
    checks++;
    if ({busy_o, rdata_valid_o, misaligned_o, decode_err_o} !== 4'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 0000",
                         {busy_o, rdata_valid_o, misaligned_o, decode_err_o});
    end
    checks++;
    if ({fifo_sel_o, fifo_rd_o, fifo_wr_o, fifo_addr_o, fifo_wrdata_o} !== 13'b0 ||
        rdata_o !== 32'h0) begin
      errors++; $display("FAIL reset_outputs: fifo=%b rdata=%h want zeros",
                         {fifo_sel_o, fifo_rd_o, fifo_wr_o, fifo_addr_o, fifo_wrdata_o}, rdata_o);
    end
    step(); step();
    rstn_i = 1'b1;
    step();
  endtask

  task automatic prefill();
    logic b; logic [4:0] f, af; logic [1:0] fa; logic [7:0] fd;
    for (int w = 0; w <= 16; w++) begin
      do_store(SzW, 32'h0001_0000 + 32'((w == 16 ? 1023 : w) * 4), $urandom, b, f, fa, fd, af);
      if (w == 0 || w == 16) begin
        checks++;
        if (b !== 1'b0 || f !== 5'b0) begin
          errors++; $display("FAIL prefill_store: busy=%b flags=%b want 0/00000", b, f);
        end
      end
    end
  endtask

  task automatic test_word();
    logic b; logic [4:0] f, af; logic [1:0] fa; logic [7:0] fd;
    logic [2:0] fl; logic [31:0] rd; logic [3:0] a4;
    do_store(SzW, 32'h0001_0000, 32'h1234_5678, b, f, fa, fd, af);
    checks++;
    if (b !== 1'b0) begin errors++; $display("FAIL sw_busy: got %b want 0", b); end
    do_load(SzW, 1'b0, 32'h0001_0000, b, fl, rd, a4);
    checks++;
    if (b !== 1'b1 || fl !== 3'b100 || rd !== 32'h1234_5678) begin
      errors++; $display("FAIL lw_basic: busy=%b flags=%b rdata=%h want 1/100/12345678", b, fl, rd);
    end
    checks++;
    if (a4 !== 4'b0) begin errors++; $display("FAIL lw_pulse_len: got %b want 0000", a4); end
  endtask

  task automatic test_byte_half();
    logic b; logic [4:0] f, af; logic [1:0] fa; logic [7:0] fd;
    logic [2:0] fl; logic [31:0] rd; logic [3:0] a4;
    logic [31:0] exp [6];
    do_store(SzB, 32'h0001_0003, 32'hAAAA_AA80, b, f, fa, fd, af);
    do_load(SzB, 1'b0, 32'h0001_0003, b, fl, rd, a4); exp[0] = rd;
    do_load(SzB, 1'b1, 32'h0001_0003, b, fl, rd, a4); exp[1] = rd;
    do_load(SzW, 1'b0, 32'h0001_0000, b, fl, rd, a4); exp[2] = rd;
    do_store(SzH, 32'h0001_0002, 32'h5555_BEEF, b, f, fa, fd, af);
    do_load(SzH, 1'b0, 32'h0001_0002, b, fl, rd, a4); exp[3] = rd;
    do_load(SzH, 1'b1, 32'h0001_0002, b, fl, rd, a4); exp[4] = rd;
    do_load(SzW, 1'b0, 32'h0001_0000, b, fl, rd, a4); exp[5] = rd;
    checks++;
    if (exp[0] !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb: got %h want ffffff80", exp[0]); end
    checks++;
    if (exp[1] !== 32'h0000_0080) begin errors++; $display("FAIL lbu: got %h want 00000080", exp[1]); end
    checks++;
    if (exp[2] !== 32'h8034_5678) begin errors++; $display("FAIL sb_lanes: got %h want 80345678", exp[2]); end
    checks++;
    if (exp[3] !== 32'hFFFF_BEEF) begin errors++; $display("FAIL lh: got %h want ffffbeef", exp[3]); end
    checks++;
    if (exp[4] !== 32'h0000_BEEF) begin errors++; $display("FAIL lhu: got %h want 0000beef", exp[4]); end
    checks++;
    if (exp[5] !== 32'hBEEF_5678) begin errors++; $display("FAIL sh_lanes: got %h want beef5678", exp[5]); end
  endtask

  task automatic test_misaligned();
    logic b; logic [4:0] f, af; logic [1:0] fa; logic [7:0] fd;
    logic [2:0] fl; logic [31:0] rd; logic [3:0] a4;
    do_load(SzW, 1'b0, 32'h0001_0001, b, fl, rd, a4);
    checks++;
    if (b !== 1'b1 || fl !== 3'b110 || rd !== 32'h0 || a4 !== 4'b0) begin
      errors++; $display("FAIL lw_misal: busy=%b flags=%b rdata=%h after=%b want 1/110/0/0000",
                         b, fl, rd, a4);
    end
    do_store(SzW, 32'h0001_0002, 32'hFFFF_FFFF, b, f, fa, fd, af);
    checks++;
    if (b !== 1'b0 || f !== 5'b10000 || af !== 5'b0) begin
      errors++; $display("FAIL sw_misal: busy=%b flags=%b after=%b want 0/10000/00000", b, f, af);
    end
    do_load(SzW, 1'b0, 32'h0001_0000, b, fl, rd, a4);
    checks++;
    if (rd !== 32'hBEEF_5678) begin errors++; $display("FAIL misal_no_write: got %h want beef5678", rd); end
    do_load(SzH, 1'b0, 32'h0003_0001, b, fl, rd, a4);
    checks++;
    if (fl !== 3'b110 || rd !== 32'h0) begin
      errors++; $display("FAIL misal_wins: flags=%b rdata=%h want 110/0", fl, rd);
    end
  endtask

  task automatic test_mmio();
    logic b; logic [4:0] f, af; logic [1:0] fa; logic [7:0] fd;
    logic [4:0] n1; logic v2; logic [31:0] rd2; logic [2:0] f2;
    do_store(SzB, 32'h0002_0001, 32'h0000_0041, b, f, fa, fd, af);
    checks++;
    if (b !== 1'b0 || f !== 5'b00101 || fa !== 2'd1 || fd !== 8'h41 || af !== 5'b0) begin
      errors++; $display("FAIL mmio_sb: busy=%b flags=%b addr=%0d data=%h after=%b want 0/00101/1/41/0",
                         b, f, fa, fd, af);
    end
    do_io_load(1'b1, 32'h0002_0000, 8'h7F, b, n1, fa, v2, rd2, f2);
    checks++;
    if (b !== 1'b1 || n1 !== 5'b11001 || fa !== 2'd0) begin
      errors++; $display("FAIL mmio_lbu_n1: busy=%b n1=%b addr=%0d want 1/11001/0", b, n1, fa);
    end
    checks++;
    if (v2 !== 1'b1 || rd2 !== 32'h0000_007F || f2 !== 3'b0) begin
      errors++; $display("FAIL mmio_lbu_n2: valid=%b rdata=%h fifo=%b want 1/0000007f/000", v2, rd2, f2);
    end
    do_io_load(1'b0, 32'h0002_0003, 8'h90, b, n1, fa, v2, rd2, f2);
    checks++;
    if (fa !== 2'd3 || rd2 !== 32'hFFFF_FF90) begin
      errors++; $display("FAIL mmio_lb: addr=%0d rdata=%h want 3/ffffff90", fa, rd2);
    end
  endtask

  task automatic test_decode();
    logic b; logic [4:0] f, af; logic [1:0] fa; logic [7:0] fd;
    logic [2:0] fl; logic [31:0] rd; logic [3:0] a4;
    logic [31:0] bad [3] = '{32'h0003_0000, 32'h0001_1000, 32'h0000_FFFC};
    for (int i = 0; i < 3; i++) begin
      do_load(SzW, 1'b0, bad[i], b, fl, rd, a4);
      checks++;
      if (fl !== 3'b101 || rd !== 32'h0 || a4 !== 4'b0) begin
        errors++; $display("FAIL decode_ld_%h: flags=%b rdata=%h after=%b want 101/0/0000",
                           bad[i], fl, rd, a4);
      end
    end
    do_load(SzW, 1'b0, 32'h0001_0FFC, b, fl, rd, a4);
    checks++;
    if (fl !== 3'b100 || rd !== exp_load(32'h0001_0FFC, SzW, 1'b0)) begin
      errors++; $display("FAIL ram_last_word: flags=%b rdata=%h want 100/%h", fl, rd,
                         exp_load(32'h0001_0FFC, SzW, 1'b0));
    end
    do_store(SzB, 32'h0002_0004, 32'h55, b, f, fa, fd, af);
    checks++;
    if (f !== 5'b01000 || fd !== 8'h0) begin
      errors++; $display("FAIL decode_st: flags=%b data=%h want 01000/00", f, fd);
    end
  endtask

  task automatic test_reset_mid_load();
    logic b; logic [2:0] fl; logic [31:0] rd; logic [3:0] a4;
    drive(1'b0, SzW, 1'b0, 32'h0001_0000, 32'h0);
    step(); idle_req();
    rstn_i = 1'b0;
    #1;
    checks++;
    if ({rdata_valid_o, busy_o} !== 2'b00) begin
      errors++; $display("FAIL rst_mid_load: valid/busy=%b want 00", {rdata_valid_o, busy_o});
    end
    step();
    rstn_i = 1'b1;
    step();
    checks++;
    if ({rdata_valid_o, busy_o, misaligned_o} !== 3'b000) begin
      errors++; $display("FAIL rst_release: got %b want 000", {rdata_valid_o, busy_o, misaligned_o});
    end
    do_load(SzW, 1'b0, 32'h0001_0000, b, fl, rd, a4);
    checks++;
    if (fl !== 3'b100 || rd !== exp_load(32'h0001_0000, SzW, 1'b0)) begin
      errors++; $display("FAIL load_after_rst: flags=%b rdata=%h want 100/%h", fl, rd,
                         exp_load(32'h0001_0000, SzW, 1'b0));
    end
  endtask

  task automatic test_back_to_back();
    logic b; logic [2:0] fl; logic [31:0] rd; logic [3:0] a4;
    logic [31:0] e1;
    e1 = exp_load(32'h0001_0004, SzW, 1'b0);
    drive(1'b0, SzW, 1'b0, 32'h0001_0004, 32'h0);
    step();
    drive(1'b1, SzW, 1'b0, 32'h0001_0008, 32'hDEAD_BEEF);
    #1;
    checks++;
    if (busy_o !== 1'b1 || rdata_valid_o !== 1'b1 || rdata_o !== e1) begin
      errors++; $display("FAIL b2b_load: busy=%b valid=%b rdata=%h want 1/1/%h",
                         busy_o, rdata_valid_o, rdata_o, e1);
    end
    step();
    drive(1'b1, SzW, 1'b0, 32'h0001_0004, 32'hCAFE_F00D);
    apply_store(32'h0001_0004, SzW, 32'hCAFE_F00D);
    #1;
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL b2b_store_busy: got %b want 0", busy_o); end
    step(); idle_req();
    do_load(SzW, 1'b0, 32'h0001_0004, b, fl, rd, a4);
    checks++;
    if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL b2b_store: got %h want cafef00d", rd); end
    do_load(SzW, 1'b0, 32'h0001_0008, b, fl, rd, a4);
    checks++;
    if (rd !== exp_load(32'h0001_0008, SzW, 1'b0)) begin
      errors++; $display("FAIL busy_not_sampled: got %h want %h", rd,
                         exp_load(32'h0001_0008, SzW, 1'b0));
    end
  endtask

  task automatic test_random();
    logic b; logic [4:0] f, af; logic [1:0] fa; logic [7:0] fd;
    logic [2:0] fl; logic [31:0] rd; logic [3:0] a4;
    logic [4:0] n1; logic v2; logic [31:0] rd2; logic [2:0] f2;
    logic [31:0] unm [5] = '{32'h0003_0000, 32'h0000_FFF0, 32'h0001_1004, 32'h0002_0004, 32'hFFFF_FFF8};
    logic [31:0] a, wd, ex;
    logic [1:0] sz; logic uns, we, mis, dec, io;
    logic [7:0] byt;
    for (int it = 0; it < 200; it++) begin
      int kind;
      kind = $urandom_range(0, 9);
      sz = 2'($urandom_range(0, 2)); uns = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1)); wd = $urandom;
      if (kind < 7)      a = pool_addr();
      else if (kind < 9) a = 32'h0002_0000 + 32'($urandom_range(0, 3));
      else               a = unm[$urandom_range(0, 4)] + 32'($urandom_range(0, 3));
      if (in_mmio(a) && !we) sz = SzB;
      mis = is_misal(sz, a);
      dec = !mis && !in_ram(a) && !in_mmio(a);
      io  = !mis && in_mmio(a);
      if (we) begin
        do_store(sz, a, wd, b, f, fa, fd, af);
        checks++;
        if (b !== 1'b0 || f !== {mis, dec, io, 1'b0, io} ||
            fa !== (io ? a[1:0] : 2'd0) || fd !== (io ? wd[7:0] : 8'h0) || af !== 5'b0) begin
          errors++; $display("FAIL rnd_store a=%h sz=%0d: busy=%b flags=%b addr=%0d data=%h after=%b",
                             a, sz, b, f, fa, fd, af);
        end
      end else if (io) begin
        byt = 8'($urandom);
        do_io_load(uns, a, byt, b, n1, fa, v2, rd2, f2);
        checks++;
        if (b !== 1'b1 || n1 !== 5'b11001 || fa !== a[1:0] || v2 !== 1'b1 ||
            rd2 !== exp_io(byt, uns) || f2 !== 3'b0) begin
          errors++; $display("FAIL rnd_io_load a=%h: n1=%b addr=%0d valid=%b rdata=%h want %h",
                             a, n1, fa, v2, rd2, exp_io(byt, uns));
        end
      end else begin
        ex = exp_load(a, sz, uns);
        do_load(sz, uns, a, b, fl, rd, a4);
        checks++;
        if (b !== 1'b1 || fl !== {1'b1, mis, dec} || rd !== ex || a4 !== 4'b0) begin
          errors++; $display("FAIL rnd_load a=%h sz=%0d u=%b: flags=%b rdata=%h after=%b want %b/%h",
                             a, sz, uns, fl, rd, a4, {1'b1, mis, dec}, ex);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    prefill();
    test_word();
    test_byte_half();
    test_misaligned();
    test_mmio();
    test_decode();
    test_reset_mid_load();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
